// File: rtl/buffer_ctrl_pkg.sv
// Shared types and constants for the buffer_b read/write schedulers.
package buffer_ctrl_pkg;

    // Default requester count; the tag owner field is sized from it.
    localparam int BUFB_NUM_REQ      = 4;
    // Fixed buffer_b read latency, address-valid to data-valid.
    localparam int BUFB_READ_LATENCY = 4;
    localparam int TAG_OWNER_WIDTH   = $clog2(BUFB_NUM_REQ);

    // Per-beat tag carried alongside an outstanding buffer read.
    typedef struct packed {
        logic                       vld;
        logic [TAG_OWNER_WIDTH-1:0] owner;
        logic                       last;
    } rd_tag_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// above ptr, wrapping modulo N. Shared by the read and write schedulers.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    // Scan from ptr upward and stop at the first pending request.
    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/buffer_b_read_sched.sv
// Shares buffer_b's single mm read port among NUM_REQ requesters: grants
// bursts round-robin, issues one address per cycle, tracks each beat's
// owner through the read latency and routes returned data back.
module buffer_b_read_sched
    import buffer_ctrl_pkg::*;
#(
    parameter int NUM_REQ           = BUFB_NUM_REQ,
    parameter int BUFFER_ADDR_WIDTH = 9,
    parameter int BUFFER_DATA_WIDTH = 512,
    parameter int LEN_WIDTH         = 8,
    parameter int READ_LATENCY      = BUFB_READ_LATENCY
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*BUFFER_ADDR_WIDTH-1:0]   req_base,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]           req_len,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic                                   buf_rd_addr_valid,
    output logic [BUFFER_ADDR_WIDTH-1:0]           buf_rd_addr,
    input  logic                                   buf_rd_data_valid,
    input  logic [BUFFER_DATA_WIDTH-1:0]           buf_rd_data,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    output logic [BUFFER_DATA_WIDTH-1:0]           rsp_data,
    output logic                                   rsp_last,
    output logic                                   busy,
    output logic                                   err_unexpected
);

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_e                 state_reg;
    logic [IDX_W-1:0]             owner_reg;
    logic [IDX_W-1:0]             rr_ptr_reg;
    logic [BUFFER_ADDR_WIDTH-1:0] cur_addr_reg;
    logic [LEN_WIDTH-1:0]         remaining_reg;
    logic                         buf_rd_addr_valid_reg;
    logic [BUFFER_ADDR_WIDTH-1:0] buf_rd_addr_reg;
    rd_tag_t                      issue_tag_reg;
    rd_tag_t                      tag_pipe_reg [READ_LATENCY];
    logic                         err_reg;

    logic [NUM_REQ-1:0]           arb_grant;
    logic [IDX_W-1:0]             arb_idx;
    logic                         accept;
    logic [BUFFER_ADDR_WIDTH-1:0] sel_base;
    logic [LEN_WIDTH-1:0]         sel_len;
    logic [IDX_W-1:0]             rr_ptr_next;
    logic [READ_LATENCY-1:0]      pipe_vld;
    rd_tag_t                      tail;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Grants are only offered while idle; the arbiter already masks with req_valid.
    assign req_ready   = (state_reg == IDLE) ? arb_grant : '0;
    assign accept      = (state_reg == IDLE) && (arb_grant != '0);
    assign sel_base    = req_base[arb_idx*BUFFER_ADDR_WIDTH +: BUFFER_ADDR_WIDTH];
    assign sel_len     = req_len[arb_idx*LEN_WIDTH +: LEN_WIDTH];
    assign rr_ptr_next = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;

    // Burst FSM: one address per cycle while in BURST, registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg             <= IDLE;
            owner_reg             <= '0;
            rr_ptr_reg            <= '0;
            cur_addr_reg          <= '0;
            remaining_reg         <= '0;
            buf_rd_addr_valid_reg <= 1'b0;
            buf_rd_addr_reg       <= '0;
            issue_tag_reg         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    buf_rd_addr_valid_reg <= 1'b0;
                    buf_rd_addr_reg       <= '0;
                    issue_tag_reg         <= '0;
                    if (accept) begin
                        owner_reg     <= arb_idx;
                        cur_addr_reg  <= sel_base;
                        remaining_reg <= sel_len;
                        state_reg     <= BURST;
                    end
                end
                BURST: begin
                    buf_rd_addr_valid_reg <= 1'b1;
                    buf_rd_addr_reg       <= cur_addr_reg;
                    cur_addr_reg          <= cur_addr_reg + 1'b1;
                    remaining_reg         <= remaining_reg - 1'b1;
                    issue_tag_reg         <= '{vld: 1'b1,
                                               owner: TAG_OWNER_WIDTH'(owner_reg),
                                               last: (remaining_reg == '0)};
                    if (remaining_reg == '0) begin
                        rr_ptr_reg <= rr_ptr_next;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Tag shift register fed from the registered issue tag, so the tail lines
    // up with the data returned READ_LATENCY cycles after buf_rd_addr_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe_reg[i] <= '0;
            end
        end else begin
            tag_pipe_reg[0] <= issue_tag_reg;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_pipe_reg[i] <= tag_pipe_reg[i-1];
            end
        end
    end

    assign tail = tag_pipe_reg[READ_LATENCY-1];

    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe_vld
            assign pipe_vld[gi] = tag_pipe_reg[gi].vld;
        end
        // Only a matched cycle (data and tag both valid) reaches a requester.
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = buf_rd_data_valid & tail.vld &
                                   (tail.owner == TAG_OWNER_WIDTH'(gi));
        end
    endgenerate

    // Sticky protocol error: data without a tag, or a tag without data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (buf_rd_data_valid != tail.vld) begin
            err_reg <= 1'b1;
        end
    end

    assign rsp_last          = tail.last & (rsp_valid != '0);
    assign rsp_data          = buf_rd_data;
    assign buf_rd_addr_valid = buf_rd_addr_valid_reg;
    assign buf_rd_addr       = buf_rd_addr_reg;
    assign busy              = (state_reg == BURST) | issue_tag_reg.vld | (|pipe_vld);
    assign err_unexpected    = err_reg;

endmodule

// File: tb/tb_buffer_b_read_sched.sv
// Directed bench for buffer_b_read_sched with a fixed-latency buffer model.
`timescale 1ns/1ps
module tb_buffer_b_read_sched;

    localparam int NR = 4;
    localparam int AW = 9;
    localparam int DW = 512;
    localparam int LW = 8;
    localparam int RL = 4;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_base;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     req_ready;
    logic              buf_rd_addr_valid;
    logic [AW-1:0]     buf_rd_addr;
    logic              buf_rd_data_valid;
    logic [DW-1:0]     buf_rd_data;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_last;
    logic              busy;
    logic              err_unexpected;

    buffer_b_read_sched #(
        .NUM_REQ           (NR),
        .BUFFER_ADDR_WIDTH (AW),
        .BUFFER_DATA_WIDTH (DW),
        .LEN_WIDTH         (LW),
        .READ_LATENCY      (RL)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_base          (req_base),
        .req_len           (req_len),
        .req_ready         (req_ready),
        .buf_rd_addr_valid (buf_rd_addr_valid),
        .buf_rd_addr       (buf_rd_addr),
        .buf_rd_data_valid (buf_rd_data_valid),
        .buf_rd_data       (buf_rd_data),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .rsp_last          (rsp_last),
        .busy              (busy),
        .err_unexpected    (err_unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int beats[NR];
    int lasts[NR];
    int last_at[NR];
    int last_cyc;
    int cyc_cnt;
    int g_lane[8];
    int g_cyc[8];
    logic inject;

    typedef struct {
        int           lane;
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        logic [AW-1:0] exp_last;
    } vec_t;
    vec_t vecs[4];

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = {7'(k), 16'hC0DE, a};
        return d;
    endfunction

    // Buffer model: fixed read latency, data is a pattern of the address.
    logic          mv [RL];
    logic [AW-1:0] ma [RL];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RL; i++) begin
                mv[i] <= 1'b0;
                ma[i] <= '0;
            end
        end else begin
            mv[0] <= buf_rd_addr_valid;
            ma[0] <= buf_rd_addr;
            for (int i = 1; i < RL; i++) begin
                mv[i] <= mv[i-1];
                ma[i] <= ma[i-1];
            end
        end
    end
    assign buf_rd_data_valid = mv[RL-1] | inject;
    assign buf_rd_data       = pat(ma[RL-1]);

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NR; i++) begin
            beats[i] = 0; lasts[i] = 0; last_at[i] = 0;
        end
        last_cyc = -1;
    endtask

    function automatic int idx_of(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Response monitor: one-hot, data integrity, beat/last bookkeeping.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rsp_valid != '0) begin
                    check("rsp_onehot", 64'($countones(rsp_valid)), 64'd1);
                    checks++;
                    if (rsp_data !== pat(ma[RL-1])) begin
                        errors++;
                        $display("FAIL rsp_data actual=%h required=%h", rsp_data[31:0], pat(ma[RL-1]) & 32'hFFFFFFFF);
                    end
                    for (int i = 0; i < NR; i++) begin
                        if (rsp_valid[i]) begin
                            beats[i]++;
                            if (rsp_last) begin
                                lasts[i]++;
                                last_at[i] = beats[i];
                                last_cyc = cyc_cnt;
                            end
                        end
                    end
                end else begin
                    check("rsp_last_idle", 64'(rsp_last), 64'd0);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic run_burst(input int lane, input logic [AW-1:0] base,
                             input logic [LW-1:0] len, input logic [AW-1:0] exp_last);
        int n;
        int drop_cyc;
        clear_stats();
        req_valid[lane] = 1'b1;
        req_base[lane*AW +: AW] = base;
        req_len[lane*LW +: LW] = len;
        #1;
        check("req_ready", 64'(req_ready), 64'(1 << lane));
        @(posedge clk); #1;
        req_valid[lane] = 1'b0;
        check("busy_on_accept", 64'(busy), 64'd1);
        for (int i = 0; i <= int'(len); i++) begin
            @(posedge clk); #1;
            check("addr_valid", 64'(buf_rd_addr_valid), 64'd1);
            check("addr", 64'(buf_rd_addr), 64'(AW'(base + AW'(i))));
            if (i == int'(len)) check("addr_last", 64'(buf_rd_addr), 64'(exp_last));
        end
        @(posedge clk); #1;
        check("addr_gap", 64'(buf_rd_addr_valid), 64'd0);
        n = 0;
        while (busy && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        drop_cyc = cyc_cnt;
        check("busy_timeout", 64'(busy), 64'd0);
        check("busy_drop_cycle", 64'(drop_cyc), 64'(last_cyc + 1));
        check("beats", 64'(beats[lane]), 64'(int'(len) + 1));
        check("last_count", 64'(lasts[lane]), 64'd1);
        check("last_position", 64'(last_at[lane]), 64'(int'(len) + 1));
        check("no_err", 64'(err_unexpected), 64'd0);
    endtask

    // Record the lane and edge index of each accept; optionally drop accepted lanes.
    task automatic collect(input int ngr, input bit drop);
        int n = 0;
        int c = 0;
        logic [NR-1:0] g;
        while (n < ngr && c < 80) begin
            #1;
            g = req_ready & req_valid;
            if (g != '0) begin
                g_lane[n] = idx_of(g);
                g_cyc[n] = c;
                n++;
            end
            @(posedge clk); #1;
            if (drop) req_valid = req_valid & ~g;
            c++;
        end
        check("grant_count", 64'(n), 64'(ngr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 9'h010, 8'd3, 9'h013};
        vecs[1] = '{1, 9'h123, 8'd5, 9'h128};
        vecs[2] = '{2, 9'h1FE, 8'd3, 9'h001};
        vecs[3] = '{3, 9'h0A0, 8'd0, 9'h0A0};

        rst_n = 1'b0; req_valid = '0; req_base = '0; req_len = '0; inject = 1'b0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_addr_valid", 64'(buf_rd_addr_valid), 64'd0);
        check("rst_addr", 64'(buf_rd_addr), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_last", 64'(rsp_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_unexpected), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single bursts from the table, including address wrap and len=0.
        for (int v = 0; v < 4; v++) begin
            run_burst(vecs[v].lane, vecs[v].base, vecs[v].len, vecs[v].exp_last);
            @(posedge clk); #1;
        end

        // Contention: all lanes, len=0, two rounds.
        for (int r = 0; r < 2; r++) begin
            clear_stats();
            for (int i = 0; i < NR; i++) begin
                req_base[i*AW +: AW] = AW'(9'h100 + 9'(i*16));
                req_len[i*LW +: LW] = '0;
            end
            req_valid = '1;
            collect(4, 1'b1);
            for (int k = 0; k < 4; k++) check("contention_order", 64'(g_lane[k]), 64'(k));
            if (r == 0) begin
                for (int k = 1; k < 4; k++) check("contention_gap", 64'(g_cyc[k] - g_cyc[k-1]), 64'd2);
            end
            wait_idle();
            for (int i = 0; i < NR; i++) begin
                check("contention_beats", 64'(beats[i]), 64'd1);
                check("contention_last", 64'(lasts[i]), 64'd1);
            end
        end

        // Fairness: lanes 1 and 2 held valid continuously.
        clear_stats();
        req_len[1*LW +: LW] = 8'd1;
        req_len[2*LW +: LW] = 8'd1;
        req_valid = 4'b0110;
        collect(6, 1'b0);
        req_valid = '0;
        for (int k = 0; k < 6; k++) check("fair_order", 64'(g_lane[k]), 64'((k % 2 == 0) ? 1 : 2));
        wait_idle();
        check("fair_beats1", 64'(beats[1]), 64'd6);
        check("fair_beats2", 64'(beats[2]), 64'd6);
        check("fair_no_err", 64'(err_unexpected), 64'd0);

        // Error: data valid with an empty tag pipe.
        clear_stats();
        inject = 1'b1;
        #1;
        check("err_rsp_suppressed", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        inject = 1'b0;
        check("err_set", 64'(err_unexpected), 64'd1);
        repeat (5) begin @(posedge clk); #1; end
        check("err_sticky", 64'(err_unexpected), 64'd1);
        check("err_no_rsp", 64'(beats[0] + beats[1] + beats[2] + beats[3]), 64'd0);

        // Reset during beat 2 of a len=7 burst.
        clear_stats();
        req_base[0 +: AW] = 9'h040;
        req_len[0 +: LW] = 8'd7;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_beat2_addr", 64'(buf_rd_addr), 64'h042);
        rst_n = 1'b0;
        #1;
        check("mid_rst_addr_valid", 64'(buf_rd_addr_valid), 64'd0);
        check("mid_rst_addr", 64'(buf_rd_addr), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_err", 64'(err_unexpected), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        check("post_rst_no_rsp", 64'(beats[0] + beats[1] + beats[2] + beats[3]), 64'd0);
        check("post_rst_err", 64'(err_unexpected), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        run_burst(1, 9'h155, 8'd2, 9'h157);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
